life_grid_engine: RTL and testbench

- Parametrised Game-of-Life engine: ROWS x COLS board register, B3/S23 rules, internal generation timer, run/pause and single-step control.
- Row-serial output streamer with a valid/ready handshake; feeds the UART/LED display path one row per transfer.
- Sits between the board top level (keys, default pattern) and the display/JTAG writer.
- Replaces free-running divided clocks with a single-clock, tick-enabled design.

---
 rtl/life_grid_engine.sv | 156 +++++++++++++++
 tb/tb_life_grid_engine.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/life_grid_engine.sv
// rtl/life_grid_engine.sv - Game-of-Life board engine with B3/S23 rules, generation timer and row streamer
//
// Optional feature: define LIFE_GRID_WRAP_EN for a toroidal board; otherwise
// neighbours outside the grid count as dead.
//
// Ports:
//   clk, reset          single clock, synchronous active-high reset
//   load, data          level load of the whole board; cell (r,c) = data[r*COLS+c]
//   run, step           free-running advance every TICK_DIV cycles / single step while paused
//   board, gen_count    current board and generations since last load/reset
//   row_data, row_idx,
//   row_valid, row_ready,
//   row_last            one board row per valid/ready transfer, row_last on row ROWS-1
//   stream_busy         a frame is being streamed
module life_grid_engine #(
  parameter int ROWS     = 8,
  parameter int COLS     = 8,
  parameter int TICK_DIV = 16778523,
  parameter int GEN_W    = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [ROWS*COLS-1:0]    data,
  input  logic                    run,
  input  logic                    step,
  output logic [ROWS*COLS-1:0]    board,
  output logic [GEN_W-1:0]        gen_count,
  output logic [COLS-1:0]         row_data,
  output logic [$clog2(ROWS)-1:0] row_idx,
  output logic                    row_valid,
  input  logic                    row_ready,
  output logic                    row_last,
  output logic                    stream_busy
);

  localparam int N  = ROWS * COLS;
  localparam int IW = $clog2(ROWS);
  localparam int TW = $clog2(TICK_DIV);

  typedef enum logic {IDLE, SEND} state_t;

  // Returns the cell at (r,c) as a 4-bit value so eight of them can be summed.
  function automatic logic [3:0] cell_at(input logic [N-1:0] b, input int r, input int c);
`ifdef LIFE_GRID_WRAP_EN
    return 4'((b >> (((r + ROWS) % ROWS) * COLS + ((c + COLS) % COLS))) & N'(1));
`else
    if (r < 0 || r >= ROWS || c < 0 || c >= COLS) return 4'd0;
    return 4'((b >> (r * COLS + c)) & N'(1));
`endif
  endfunction

  logic [N-1:0]    next_board;
  logic [TW-1:0]   tick_cnt;
  logic            tick_last;
  logic            advance;
  logic            req;
  state_t          state, state_n;
  logic [N-1:0]    snapshot;
  logic [N-1:0]    snap_sh;
  logic [IW-1:0]   idx_n;
  logic            pending, pend_n;
  logic            snap_load;

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      logic [3:0] n;
      assign n = cell_at(board, r - 1, c - 1) + cell_at(board, r - 1, c) + cell_at(board, r - 1, c + 1)
               + cell_at(board, r,     c - 1)                           + cell_at(board, r,     c + 1)
               + cell_at(board, r + 1, c - 1) + cell_at(board, r + 1, c) + cell_at(board, r + 1, c + 1);
      assign next_board[r*COLS+c] = board[r*COLS+c] ? (n == 4'd2 || n == 4'd3) : (n == 4'd3);
    end
  end

  assign tick_last = (tick_cnt == TW'(TICK_DIV - 1));
  // step only matters while paused; the timer owns advancing while running.
  assign advance   = run ? tick_last : step;

  always_ff @(posedge clk) begin
    if (reset) begin
      board     <= '0;
      gen_count <= '0;
      tick_cnt  <= '0;
      req       <= 1'b0;
    end else begin
      // Frame request lags the board update by one cycle so the streamer
      // snapshots the freshly written board.
      req <= load | advance;
      if (load) begin
        board     <= data;
        gen_count <= '0;
        tick_cnt  <= '0;
      end else begin
        tick_cnt <= (run && !tick_last) ? tick_cnt + TW'(1) : '0;
        if (advance) begin
          board     <= next_board;
          gen_count <= gen_count + GEN_W'(1);
        end
      end
    end
  end

  always_comb begin
    state_n   = state;
    idx_n     = row_idx;
    pend_n    = pending;
    snap_load = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          state_n   = SEND;
          snap_load = 1'b1;
          idx_n     = '0;
        end
      end
      SEND: begin
        if (req) pend_n = 1'b1;
        if (row_ready) begin
          if (row_idx != IW'(ROWS - 1)) begin
            idx_n = row_idx + IW'(1);
          end else if (pending || req) begin
            // Back-to-back frame: every queued request collapses into one re-snapshot.
            snap_load = 1'b1;
            idx_n     = '0;
            pend_n    = 1'b0;
          end else begin
            state_n = IDLE;
            idx_n   = '0;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      snapshot <= '0;
      row_idx  <= '0;
      pending  <= 1'b0;
    end else begin
      state   <= state_n;
      row_idx <= idx_n;
      pending <= pend_n;
      if (snap_load) snapshot <= board;
    end
  end

  assign snap_sh     = snapshot >> (int'(row_idx) * COLS);
  assign row_data    = snap_sh[COLS-1:0];
  assign row_valid   = (state == SEND);
  assign stream_busy = (state == SEND);
  assign row_last    = row_valid && (row_idx == IW'(ROWS - 1));

endmodule

// File: tb/tb_life_grid_engine.sv
// tb/tb_life_grid_engine.sv - self-checking bench for life_grid_engine
module tb_life_grid_engine;

  localparam int ROWS = 8;
  localparam int COLS = 8;
  localparam int TDIV = 4;
  localparam int GW   = 16;
`ifdef LIFE_GRID_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  localparam logic [63:0] BLINKER = 64'h0000_0000_1C00_0000;
  localparam logic [63:0] BLINK_V = 64'h0000_0008_0808_0000;
  localparam logic [63:0] BLOCK   = 64'h0000_0018_1800_0000;
  localparam logic [63:0] EDGE83  = 64'h0000_0000_0000_0083;
  localparam logic [63:0] GLIDER  = 64'h0000_0000_0007_0402;
  localparam logic [63:0] GLIDER4 = 64'h0000_0000_0E08_0400;

  logic        clk = 1'b0;
  logic        reset, load, run, step, row_ready;
  logic [63:0] data;
  logic [63:0] board;
  logic [15:0] gen_count;
  logic [7:0]  row_data;
  logic [2:0]  row_idx;
  logic        row_valid, row_last, stream_busy;

  always #5 clk = ~clk;

  life_grid_engine #(.ROWS(ROWS), .COLS(COLS), .TICK_DIV(TDIV), .GEN_W(GW)) dut (
    .clk(clk), .reset(reset), .load(load), .data(data), .run(run), .step(step),
    .board(board), .gen_count(gen_count), .row_data(row_data), .row_idx(row_idx),
    .row_valid(row_valid), .row_ready(row_ready), .row_last(row_last),
    .stream_busy(stream_busy)
  );

  int total  = 0;
  int passed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [63:0] p);
    load = 1'b1;
    data = p;
    cyc();
    load = 1'b0;
  endtask

  task automatic do_step();
    step = 1'b1;
    cyc();
    step = 1'b0;
    cyc();
  endtask

  // Reference generation: grid of cells, explicit neighbour walk.
  function automatic logic [63:0] ref_next(input logic [63:0] b);
    bit          g[ROWS][COLS];
    logic [63:0] o;
    int          n, rr, cc;
    o = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        g[r][c] = b[r*COLS+c];
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        n = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if (dr == 0 && dc == 0) continue;
            rr = r + dr;
            cc = c + dc;
            if (WRAP) begin
              rr = (rr + ROWS) % ROWS;
              cc = (cc + COLS) % COLS;
            end else if (rr < 0 || rr >= ROWS || cc < 0 || cc >= COLS) begin
              continue;
            end
            n += int'(g[rr][cc]);
          end
        end
        o[r*COLS+c] = (n == 3) || (g[r][c] && n == 2);
      end
    end
    return o;
  endfunction

  function automatic logic [7:0] row_of(input logic [63:0] p, input int k);
    logic [63:0] t;
    t = p >> (k * COLS);
    return t[7:0];
  endfunction

  typedef struct {
    logic [63:0] pattern;
    int          steps;
    logic [63:0] expect_board;
  } vec_t;

  vec_t        vecs[5];
  logic [63:0] exp_b;
  logic [63:0] frames[2];
  int          nrx, nvalid, n;
  bit          want_valid, found;

  initial begin
    vecs[0] = '{BLINKER, 1, BLINK_V};
    vecs[1] = '{BLINKER, 2, BLINKER};
    vecs[2] = '{BLOCK,   3, BLOCK};
    vecs[3] = '{EDGE83,  1, WRAP ? 64'h0100_0000_0000_0101 : 64'h0};
    vecs[4] = '{GLIDER,  4, GLIDER4};

    reset = 1'b1; load = 1'b0; data = '0; run = 1'b0; step = 1'b0; row_ready = 1'b0;
    cyc(); cyc();
    check("rst_board", board, 64'h0);
    check("rst_gen", gen_count, 0);
    check("rst_valid", row_valid, 0);
    check("rst_idx", row_idx, 0);
    check("rst_data", row_data, 0);
    check("rst_last", row_last, 0);
    check("rst_busy", stream_busy, 0);
    reset = 1'b0;

    // Streaming with back-pressure, then full-rate drain.
    do_load(BLINKER);
    check("lat_valid_early", row_valid, 0);
    cyc();
    check("lat_valid", row_valid, 1);
    for (int k = 0; k < 5; k++) begin
      cyc();
      check("hold_valid", row_valid, 1);
      check("hold_idx", row_idx, 0);
      check("hold_data", row_data, row_of(BLINKER, 0));
    end
    row_ready = 1'b1;
    for (int k = 0; k < ROWS; k++) begin
      check("drain_idx", row_idx, k);
      check("drain_data", row_data, row_of(BLINKER, k));
      check("drain_last", row_last, (k == ROWS - 1));
      cyc();
    end
    check("drain_done", row_valid, 0);

    // Table of known patterns stepped while paused.
    for (int i = 0; i < 5; i++) begin
      do_load(vecs[i].pattern);
      for (int s = 0; s < vecs[i].steps; s++) do_step();
      check("vec_board", board, vecs[i].expect_board);
      check("vec_gen", gen_count, vecs[i].steps);
    end

    // Random boards against the reference model.
    for (int i = 0; i < 20; i++) begin
      exp_b = {$urandom, $urandom};
      do_load(exp_b);
      n = $urandom_range(1, 3);
      for (int s = 0; s < n; s++) begin
        do_step();
        exp_b = ref_next(exp_b);
        check("rand_board", board, exp_b);
      end
      check("rand_gen", gen_count, n);
    end

    // Free-running timer on a still life.
    do_load(BLOCK);
    run = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      cyc();
      check("run_gen", gen_count, k / TDIV);
    end
    check("run_board", board, BLOCK);
    cyc(); cyc();
    run = 1'b0;
    cyc(); cyc(); cyc();
    check("pause_gen", gen_count, 10);
    run = 1'b1;
    step = 1'b1;
    cyc();
    step = 1'b0;
    check("restart_gen1", gen_count, 10);
    cyc(); cyc();
    check("restart_gen3", gen_count, 10);
    cyc();
    check("restart_gen4", gen_count, 11);
    run = 1'b0;

    // Two steps during one frame coalesce into exactly one follow-on frame.
    row_ready = 1'b1;
    for (int k = 0; k < 30; k++) cyc();
    check("idle_before", stream_busy, 0);
    row_ready = 1'b0;
    do_load(GLIDER);
    frames[0] = GLIDER;
    frames[1] = ref_next(ref_next(GLIDER));
    nrx = 0;
    want_valid = 1'b0;
    for (int c = 0; c < 400 && nrx < 16; c++) begin
      step = (c == 3 || c == 6);
      row_ready = 1'($urandom_range(0, 1));
      if (want_valid) begin
        check("no_bubble", {row_valid, row_idx}, {1'b1, 3'd0});
        want_valid = 1'b0;
      end
      if (row_valid && row_ready) begin
        check("co_idx", row_idx, nrx % ROWS);
        check("co_data", row_data, row_of(frames[nrx / ROWS], nrx % ROWS));
        check("co_last", row_last, (nrx % ROWS == ROWS - 1));
        nrx++;
        if (nrx == ROWS) want_valid = 1'b1;
      end
      cyc();
    end
    step = 1'b0;
    check("co_rows", nrx, 16);
    check("co_gen", gen_count, 2);
    row_ready = 1'b1;
    nvalid = 0;
    for (int k = 0; k < 12; k++) begin
      if (row_valid) nvalid++;
      cyc();
    end
    check("co_no_extra", nvalid, 0);

    // Reset in the middle of a frame.
    do_load(BLINKER);
    do_step();
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (row_valid && row_idx == 3'd4) found = 1'b1;
      else cyc();
    end
    check("mid_found", found, 1);
    check("mid_gen_before", gen_count, 1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check("mid_valid", row_valid, 0);
    check("mid_board", board, 64'h0);
    check("mid_gen", gen_count, 0);
    check("mid_busy", stream_busy, 0);

    // load beats a simultaneous step.
    do_load(BLINKER);
    do_step();
    check("ls_pre_gen", gen_count, 1);
    load = 1'b1;
    step = 1'b1;
    data = GLIDER;
    cyc();
    load = 1'b0;
    step = 1'b0;
    check("ls_board", board, GLIDER);
    check("ls_gen", gen_count, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
